// File: rtl/als_pkg.sv
// Shared constants for the ALS averaging display: segment codes, FSM states
// and the BCD-to-segment lookup.
package als_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam int DIG_IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CONV,
        DONE
    } state_t;

    // Active-low segments with dp off; non-decimal codes go blank.
    function automatic logic [7:0] bcdToSeg(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/als_avg_display_seg7_scan4.sv
// Four-digit multiplexed 7-segment driver: free-running refresh counter,
// one-hot active-low anode rotation and leading-zero blanking.
module seg7_scan4
    import als_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_hundreds,
    input  logic [3:0] i_tens,
    input  logic [3:0] i_units,
    output logic [7:0] DISPLAY,
    output logic [3:0] AN
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CW-1:0]        r_refresh;
    logic [DIG_IDX_W-1:0] r_digIdx;
    logic                 w_hundBlank;
    logic                 w_tensBlank;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_refresh <= '0;
            r_digIdx  <= '0;
        end else if (r_refresh == CW'(REFRESH_DIV - 1)) begin
            r_refresh <= '0;
            r_digIdx  <= r_digIdx + 1'b1;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    // Tens only blank when hundreds is also zero, so "105" keeps its middle zero.
    always_comb begin
        w_hundBlank = (i_hundreds == 4'd0);
        w_tensBlank = w_hundBlank && (i_tens == 4'd0);
        AN          = ~(4'b0001 << r_digIdx);
        case (r_digIdx)
            2'd0:    DISPLAY = bcdToSeg(i_units);
            2'd1:    DISPLAY = w_tensBlank ? SEG_BLANK : bcdToSeg(i_tens);
            2'd2:    DISPLAY = w_hundBlank ? SEG_BLANK : bcdToSeg(i_hundreds);
            default: DISPLAY = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/als_avg_display.sv
// ALS consumer: running average over 2^AVG_LOG2 samples, sequential
// double-dabble to BCD, and a multiplexed 4-digit 7-segment readout.
module als_avg_display
    import als_pkg::*;
#(
    parameter int AVG_LOG2    = 2,
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [7:0] sample,
    output logic       busy,
    output logic       overrun,
    output logic [7:0] value,
    output logic [7:0] DISPLAY,
    output logic [3:0] AN
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = 8 + AVG_LOG2;

    logic [7:0]          r_hist [DEPTH];
    logic [SW-1:0]       r_sum;
    logic [AVG_LOG2-1:0] r_ptr;
    state_t              r_state;
    state_t              w_nextState;
    logic [2:0]          r_bitCnt;
    logic [19:0]         r_shift;
    logic [19:0]         w_adj;
    logic [3:0]          r_hundreds;
    logic [3:0]          r_tens;
    logic [3:0]          r_units;
    logic [7:0]          r_value;
    logic                r_overrun;
    logic                w_accept;

    assign busy     = (r_state != IDLE);
    assign w_accept = sample_valid && !busy;
    assign overrun  = r_overrun;
    assign value    = r_value;

    // Sliding-window sum: the slot being overwritten leaves, the new sample enters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_hist[i] <= '0;
            end
            r_sum     <= '0;
            r_ptr     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= sample_valid && busy;
            if (w_accept) begin
                r_sum         <= r_sum - SW'(r_hist[r_ptr]) + SW'(sample);
                r_hist[r_ptr] <= sample;
                r_ptr         <= r_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_accept) w_nextState = LOAD;
            LOAD: w_nextState = CONV;
            CONV: if (r_bitCnt == 3'd7) w_nextState = DONE;
            DONE: w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Double-dabble correction: nibbles at 5 or above get +3 before the shift.
    always_comb begin
        w_adj = r_shift;
        for (int k = 0; k < 3; k++) begin
            if (r_shift[8 + 4*k +: 4] >= 4'd5) begin
                w_adj[8 + 4*k +: 4] = r_shift[8 + 4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_value    <= '0;
            r_shift    <= '0;
            r_bitCnt   <= '0;
            r_hundreds <= '0;
            r_tens     <= '0;
            r_units    <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_value  <= r_sum[SW-1:AVG_LOG2];
                    r_shift  <= {12'd0, r_sum[SW-1:AVG_LOG2]};
                    r_bitCnt <= '0;
                end
                CONV: begin
                    r_shift  <= w_adj << 1;
                    r_bitCnt <= r_bitCnt + 1'b1;
                end
                DONE: begin
                    r_hundreds <= r_shift[19:16];
                    r_tens     <= r_shift[15:12];
                    r_units    <= r_shift[11:8];
                end
                default: ;
            endcase
        end
    end

    seg7_scan4 #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .i_hundreds(r_hundreds),
        .i_tens    (r_tens),
        .i_units   (r_units),
        .DISPLAY   (DISPLAY),
        .AN        (AN)
    );

endmodule
